// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, 1/2 stop bits, paced by Tick.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Tick,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  Send_Break,
`endif
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  Tx_Done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
`ifdef UART_TX_BREAK_EN
    , BREAK = 3'd6
`endif
  } state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    par_en_reg;
  logic                    par_bit_reg;
  logic                    stop2_reg;

`ifdef UART_TX_BREAK_EN
  localparam int BRK_TICKS = 2 * DATA_WIDTH + 4;
  localparam int BRK_W     = $clog2(BRK_TICKS);
  logic [BRK_W-1:0]        brk_cnt_reg;
  logic                    brk_stop_reg;
`endif

  // TX_OUT is registered from the next state, so each bit appears the cycle after its Tick.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg   <= IDLE;
      TX_OUT      <= 1'b1;
      busy        <= 1'b0;
      Tx_Done     <= 1'b0;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      stop2_reg   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_reg  <= '0;
      brk_stop_reg <= 1'b0;
`endif
    end else begin
      Tx_Done <= 1'b0;
      case (state_reg)
        IDLE: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
`ifdef UART_TX_BREAK_EN
          brk_stop_reg <= 1'b0;
          if (Send_Break) begin
            state_reg   <= BREAK;
            TX_OUT      <= 1'b0;
            busy        <= 1'b1;
            brk_cnt_reg <= '0;
          end else
`endif
          if (Data_Valid) begin
            shift_reg   <= P_DATA;
            par_en_reg  <= PAR_EN;
            par_bit_reg <= (^P_DATA) ^ PAR_TYP;
            stop2_reg   <= STOP2;
            state_reg   <= ARM;
            busy        <= 1'b1;
          end
        end
        ARM: if (Tick) begin
          state_reg <= START;
          TX_OUT    <= 1'b0;
        end
        START: if (Tick) begin
          state_reg <= DATA;
          cnt_reg   <= '0;
          TX_OUT    <= shift_reg[0];
        end
        DATA: if (Tick) begin
          shift_reg <= shift_reg >> 1;
          cnt_reg   <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_reg <= '0;
            if (par_en_reg) begin
              state_reg <= PARITY;
              TX_OUT    <= par_bit_reg;
            end else begin
              state_reg <= STOP;
              TX_OUT    <= 1'b1;
            end
          end else begin
            TX_OUT <= shift_reg[1];
          end
        end
        PARITY: if (Tick) begin
          state_reg <= STOP;
          cnt_reg   <= '0;
          TX_OUT    <= 1'b1;
        end
        STOP: if (Tick) begin
          if (stop2_reg && cnt_reg == '0) begin
            cnt_reg <= CNT_W'(1);
          end else begin
            Tx_Done <= 1'b1;
            cnt_reg <= '0;
            // Back-to-back: a request on the final stop Tick skips IDLE and ARM.
`ifdef UART_TX_BREAK_EN
            if (Data_Valid && !brk_stop_reg) begin
`else
            if (Data_Valid) begin
`endif
              shift_reg   <= P_DATA;
              par_en_reg  <= PAR_EN;
              par_bit_reg <= (^P_DATA) ^ PAR_TYP;
              stop2_reg   <= STOP2;
              state_reg   <= START;
              TX_OUT      <= 1'b0;
            end else begin
              state_reg <= IDLE;
              TX_OUT    <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: if (Tick) begin
          if (brk_cnt_reg == BRK_W'(BRK_TICKS - 1)) begin
            state_reg    <= STOP;
            stop2_reg    <= 1'b0;
            brk_stop_reg <= 1'b1;
            cnt_reg      <= '0;
            TX_OUT       <= 1'b1;
          end else begin
            brk_cnt_reg <= brk_cnt_reg + BRK_W'(1);
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          TX_OUT    <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl (DATA_WIDTH=8); break test included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Tick = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic       TX_OUT;
  logic       busy;
  logic       Tx_Done;
`ifdef UART_TX_BREAK_EN
  logic       Send_Break = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Tick       (Tick),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
`ifdef UART_TX_BREAK_EN
    .Send_Break (Send_Break),
`endif
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .Tx_Done    (Tx_Done)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One Tick pulse, then check the bit presented after it.
  task automatic tick_check(input string tag, input logic exp_tx, input logic exp_busy, input logic exp_done);
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    check({tag, ".tx"}, 32'(TX_OUT), 32'(exp_tx));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(Tx_Done), 32'(exp_done));
    step();
    step();
  endtask

  task automatic run_bits(input string tag, input logic [15:0] vec, input int first, input int last);
    for (int j = first; j <= last; j++)
      tick_check($sformatf("%s.bit%0d", tag, j), vec[j], 1'b1, 1'b0);
  endtask

  // Accept from IDLE, scramble config inputs, and verify the ARM cycle.
  task automatic accept(input string tag, input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Data_Valid = 1'b1;
    step();
    check({tag, ".acc_busy"}, 32'(busy), 32'd1);
    check({tag, ".acc_tx"}, 32'(TX_OUT), 32'd1);
    Data_Valid = 1'b0;
    P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2;
    step();
    check({tag, ".arm_tx"}, 32'(TX_OUT), 32'd1);
  endtask

  task automatic end_frame(input string tag);
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    check({tag, ".end_done"}, 32'(Tx_Done), 32'd1);
    check({tag, ".end_busy"}, 32'(busy), 32'd0);
    check({tag, ".end_tx"}, 32'(TX_OUT), 32'd1);
    step();
    check({tag, ".done_pulse"}, 32'(Tx_Done), 32'd0);
    $display("frame %s complete", tag);
  endtask

  initial begin
    // Reset held with Data_Valid high
    Data_Valid = 1'b1; P_DATA = 8'hFF;
    step();
    check("rst1.tx", 32'(TX_OUT), 32'd1);
    check("rst1.busy", 32'(busy), 32'd0);
    step();
    check("rst2.tx", 32'(TX_OUT), 32'd1);
    check("rst2.busy", 32'(busy), 32'd0);
    check("rst2.done", 32'(Tx_Done), 32'd0);
    Data_Valid = 1'b0;
    RST = 1'b1;
    step();
    tick_check("post_rst", 1'b1, 1'b0, 1'b0);
    tick_check("post_rst2", 1'b1, 1'b0, 1'b0);
    $display("reset sequence complete");

    // 0xA5, no parity, one stop: start,1,0,1,0,0,1,0,1,stop
    accept("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    run_bits("a5", 16'h034A, 0, 9);
    end_frame("a5");

    // 0x07 with even parity (bit 1), then odd parity (bit 0)
    accept("07e", 8'h07, 1'b1, 1'b0, 1'b0);
    run_bits("07e", 16'h060E, 0, 10);
    end_frame("07e");
    accept("07o", 8'h07, 1'b1, 1'b1, 1'b0);
    run_bits("07o", 16'h040E, 0, 10);
    end_frame("07o");

    // 0x81 with two stops, then back-to-back 0x3C on the final stop Tick
    accept("81", 8'h81, 1'b0, 1'b0, 1'b1);
    run_bits("81", 16'h0702, 0, 10);
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    Data_Valid = 1'b0;
    P_DATA = 8'hC3; PAR_EN = 1'b1; STOP2 = 1'b1;
    check("b2b.done", 32'(Tx_Done), 32'd1);
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.start_tx", 32'(TX_OUT), 32'd0);
    $display("frame 81 complete");
    step();
    check("b2b.done_pulse", 32'(Tx_Done), 32'd0);
    check("b2b.busy2", 32'(busy), 32'd1);
    run_bits("3c", 16'h0278, 1, 9);
    end_frame("3c");

    // Reset during data bit 3 of 0x5A
    accept("5a", 8'h5A, 1'b0, 1'b0, 1'b0);
    run_bits("5a", 16'h02B4, 0, 4);
    RST = 1'b0;
    step();
    RST = 1'b1;
    check("midrst.tx", 32'(TX_OUT), 32'd1);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(Tx_Done), 32'd0);
    step();
    tick_check("midrst.idle", 1'b1, 1'b0, 1'b0);
    $display("mid-frame reset complete");

`ifdef UART_TX_BREAK_EN
    // Break beats Data_Valid; 20 low Ticks, one stop Tick, then IDLE
    Send_Break = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h00;
    step();
    Send_Break = 1'b0; Data_Valid = 1'b0;
    check("brk.busy", 32'(busy), 32'd1);
    check("brk.tx", 32'(TX_OUT), 32'd0);
    for (int k = 1; k <= 19; k++)
      tick_check($sformatf("brk.t%0d", k), 1'b0, 1'b1, 1'b0);
    tick_check("brk.stop", 1'b1, 1'b1, 1'b0);
    Data_Valid = 1'b1;
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    Data_Valid = 1'b0;
    check("brk.end_done", 32'(Tx_Done), 32'd1);
    check("brk.end_busy", 32'(busy), 32'd0);
    check("brk.end_tx", 32'(TX_OUT), 32'd1);
    step();
    step();
    check("brk.idle_busy", 32'(busy), 32'd0);
    $display("break sequence complete");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Parametrised UART transmit frame controller, the next-generation TX control block. It integrates the frame FSM, shift register, bit counter and parity generator into one unit and drives the serial line directly. Data width, parity mode and stop-bit count are configurable per frame. The block sits between the TX data interface and the pad, and is paced by an external baud-rate Tick.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..16.
CNT_W, $clog2(DATA_WIDTH), bit-counter width (derived; not overridden).

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
Tick  input  1  one-cycle baud enable, high once per bit period.
P_DATA  input  DATA_WIDTH  parallel payload, sampled at acceptance.
Data_Valid  input  1  request to send P_DATA.
PAR_EN  input  1  1 = append a parity bit; sampled at acceptance.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled at acceptance.
STOP2  input  1  1 = two stop bits, 0 = one; sampled at acceptance.
TX_OUT  output  1  serial line; idle high; registered.
busy  output  1  high from the cycle after acceptance until the frame ends; registered.
Tx_Done  output  1  one-cycle pulse in the cycle after the last stop-bit Tick; registered.

Behaviour:
- Reset (RST=0 at a CLK edge): state goes to IDLE, TX_OUT=1, busy=0, Tx_Done=0, and the counter and shift register clear. Reset mid-frame aborts the frame immediately with no partial stop bit.
- States: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. If Data_Valid=1, the block latches P_DATA, PAR_EN, PAR_TYP and STOP2 and moves to ARM. Tick is ignored in IDLE.
- ARM: TX_OUT=1, busy=1. On Tick, moves to START. This aligns the start bit to the baud grid.
- START: TX_OUT=0. On Tick, moves to DATA with the counter at 0.
- DATA: TX_OUT = shift[0], sent LSB first. On each Tick the shift register shifts right and the counter increments. On the Tick with counter = DATA_WIDTH-1, the next state is PARITY if the latched PAR_EN=1, otherwise STOP.
- PARITY: TX_OUT = XOR-reduction of the latched data, XORed with PAR_TYP. On Tick, moves to STOP.
- STOP: TX_OUT=1. The state lasts 1 Tick, or 2 if the latched STOP2=1; the counter is reused for this.
- On the final stop Tick, Tx_Done pulses on the next cycle.
  - If Data_Valid=1 on that same cycle, the block accepts new data and goes directly to START. This is back-to-back operation with no idle bit, and busy stays high.
  - Otherwise the block returns to IDLE and busy falls.
- Data_Valid in any other state or cycle is ignored. Upstream must hold Data_Valid until busy=0, or present it on the final stop-Tick cycle.
- Configuration inputs changing mid-frame have no effect on the current frame.
- Acceptance latency: Data_Valid in IDLE at edge N gives busy=1 at N+1. The start bit begins the cycle after the first Tick seen in ARM.
- Frame length in Ticks: 1 + DATA_WIDTH + PAR_EN + (1 + STOP2).
- Undefined state encodings recover to IDLE with TX_OUT=1.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input Send_Break (1 bit) and a BREAK state.
  - Send_Break=1 in IDLE takes priority over Data_Valid.
  - The block drives TX_OUT=0 and busy=1 for 2*DATA_WIDTH+4 Ticks, then enters STOP with one stop bit, then IDLE, with a Tx_Done pulse.
  - Send_Break in any other state is ignored.
- Undefined: no Send_Break port, no BREAK state; behaviour is exactly as above.

Test Plan:
1. Reset with RST=0 for 2 cycles while Data_Valid=1 -> TX_OUT=1, busy=0, Tx_Done=0 and no frame starts; release -> frame starts only on the next Data_Valid.
2. DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=0, STOP2=0 -> TX_OUT per Tick = 0,1,0,1,0,0,1,0,1,1; one Tx_Done pulse; busy low after 10 Ticks.
3. P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; repeat with PAR_TYP=1 -> parity bit 0; both frames are 11 Ticks.
4. STOP2=1, then Data_Valid=1 with 0x3C on the final stop-Tick cycle -> second start bit follows immediately; busy never drops; two Tx_Done pulses.
5. Mid-frame, in DATA bit 3, assert RST=0 for 1 cycle -> next cycle TX_OUT=1 and busy=0; P_DATA and PAR_EN changed mid-frame earlier do not alter the transmitted bits.
6. With UART_TX_BREAK_EN, DATA_WIDTH=8: Send_Break=1 and Data_Valid=1 together in IDLE -> TX_OUT=0 for 20 Ticks, then 1 stop Tick, then IDLE; Data_Valid is ignored.
